// File: rtl/e_cpu_io_bridge.sv
// CPU-side bridge to the east-edge CPU I/O tile: streams operands out as nibbles and collects an 8-nibble result.
// Optional WAIT timeout (status 11) is built only when E_CPU_IO_BRIDGE_TIMEOUT_EN is defined.
module e_cpu_io_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        UserCLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_funct,
    input  logic [31:0] req_op_a,
    input  logic [31:0] req_op_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic [3:0]  OPA_O,
    output logic [3:0]  OPB_O,
    input  logic [3:0]  RES0_I,
    input  logic [3:0]  RES1_I
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    state_t      state;
    logic [1:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  scnt;
    logic [2:0]  rcnt;
    logic        err;
    logic [3:0]  nxt;
    logic [3:0]  next_nib;
    logic        framing;
    logic        unused_ok;

`ifdef E_CPU_IO_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tcnt;
    assign unused_ok = RES1_I[3];
`else
    assign unused_ok = ^{RES1_I[3], TIMEOUT_CYCLES[0]};
`endif

    // Beat 0 is driven straight from the request at accept, so SEND always looks one beat ahead.
    always_comb begin
        nxt      = scnt + 4'd1;
        next_nib = nxt[3] ? op_b[4*nxt[2:0] +: 4] : op_a[4*nxt[2:0] +: 4];
        framing  = RES1_I[1] ^ (rcnt == 3'd7);
    end

    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= '0;
            OPA_O      <= '0;
            OPB_O      <= '0;
            funct      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            scnt       <= '0;
            rcnt       <= '0;
            err        <= 1'b0;
`ifdef E_CPU_IO_BRIDGE_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= SEND;
                        req_ready  <= 1'b0;
                        funct      <= req_funct;
                        op_a       <= req_op_a;
                        op_b       <= req_op_b;
                        OPA_O      <= req_op_a[3:0];
                        OPB_O      <= {2'b10, req_funct};
                        scnt       <= '0;
                        rcnt       <= '0;
                        err        <= 1'b0;
                        rsp_data   <= '0;
                        rsp_status <= '0;
                    end
                end
                SEND: begin
                    if (scnt == 4'd15) begin
                        state <= WAIT;
                        OPA_O <= '0;
                        OPB_O <= '0;
`ifdef E_CPU_IO_BRIDGE_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end else begin
                        scnt  <= nxt;
                        OPA_O <= next_nib;
                        OPB_O <= {1'b1, nxt == 4'd15, funct};
                    end
                end
                WAIT: begin
                    if (RES1_I[0]) begin
                        rsp_data[4*rcnt +: 4] <= RES0_I;
                        rcnt <= rcnt + 3'd1;
                        err  <= err | RES1_I[2];
`ifdef E_CPU_IO_BRIDGE_TIMEOUT_EN
                        tcnt <= '0;
`endif
                        // Early last, or a missing last on the eighth beat, is a framing error.
                        if (framing) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= 2'b10;
                        end else if (RES1_I[1]) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= {1'b0, err | RES1_I[2]};
                        end
                    end
`ifdef E_CPU_IO_BRIDGE_TIMEOUT_EN
                    else if (tcnt == TO_LAST) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= 2'b11;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/e_cpu_io_bridge.md
# e_cpu_io_bridge

CPU-side bridge feeding the east-edge CPU I/O tile of the fabric. Accepts a 32-bit operand pair plus a 2-bit function code from the CPU, streams it into the fabric as nibbles over OPA_O/OPB_O, then collects an 8-nibble result from RES0_I/RES1_I and returns a 32-bit response with status. Sits between the CPU custom-instruction port and the E_CPU_IO tile.

## Interface
- TIMEOUT_CYCLES, 255: idle cycles allowed between result beats in WAIT; legal 1..65535.
- UserCLK  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- req_valid  in  1  CPU request valid
- req_ready  out  1  high only in IDLE
- req_funct  in  2  function code forwarded to fabric
- req_op_a  in  32  operand A
- req_op_b  in  32  operand B
- rsp_valid  out  1  response valid, held until accepted
- rsp_ready  in  1  CPU accepts response
- rsp_data  out  32  assembled result
- rsp_status  out  2  00 ok, 01 fabric error, 10 framing error, 11 timeout
- OPA_O  out  4  operand data nibble
- OPB_O  out  4  [3] beat strobe, [2] last beat, [1:0] funct
- RES0_I  in  4  result data nibble
- RES1_I  in  4  [0] result valid, [1] result last, [2] fabric error, [3] ignored

## Operation
- States: IDLE, SEND, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch funct/op_a/op_b, clear result register, beat count, error flag; -> SEND.
- SEND: 16 beats, one per cycle, counter scnt 0..15. Beats 0-7 carry op_a[4*scnt+3:4*scnt] on OPA_O (LSB nibble first); beats 8-15 carry op_b nibbles likewise. OPB_O[3]=1 every beat, OPB_O[2]=1 on beat 15 only, OPB_O[1:0]=funct. After beat 15 -> WAIT. RES1_I is ignored in SEND.
- OPA_O/OPB_O are registered; 0 whenever not in SEND.
- WAIT: on RES1_I[0]=1, write RES0_I into rsp_data nibble rcnt, OR RES1_I[2] into error flag, rcnt++.
  - Valid with last and rcnt==7 -> RESP, status 01 if error flag (including this beat) else 00.
  - Valid with last and rcnt<7, or valid without last at rcnt==7 -> RESP, status 10; the offending nibble is still written.
  - Framing error has priority over fabric error.
  - Timeout counter clears on WAIT entry and on every valid beat; otherwise increments; reaching TIMEOUT_CYCLES -> RESP, status 11, rsp_data holds partial nibbles, unreceived nibbles 0.
  - Valid beat and timeout threshold in the same cycle: the beat wins.
- RESP: rsp_valid=1, rsp_data/rsp_status stable until rsp_ready; on rsp_ready -> IDLE (req_ready=1 next cycle). Result beats arriving in RESP/IDLE are ignored.
- reset at any point: immediate return to IDLE, in-flight transfer discarded, no response issued.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_status=0, OPA_O=0, OPB_O=0.
- Request accepted at edge 0 -> beat 0 on outputs after edge 0 (cycle 1), beat 15 in cycle 16, WAIT from cycle 17.
- Earliest response: 8 consecutive result beats in cycles 17-24 -> rsp_valid in cycle 25.
- rsp_ready may be high before rsp_valid; handshake completes on the first edge where both are high.
- Back-to-back: IDLE lasts at least one cycle between transactions.

## Configuration
- E_CPU_IO_BRIDGE_TIMEOUT_EN defined: timeout counter and status 11 present as above.
- Undefined: no counter; WAIT waits indefinitely for result beats; status 11 is never produced; TIMEOUT_CYCLES is unused.

## Test plan
- Reset mid-SEND at beat 5 -> OPA_O=OPB_O=0 and req_ready=1 asynchronously; no rsp_valid ever.
- op_a=0x76543210, op_b=0xFEDCBA98, funct=2 -> OPA_O 0,1,..,7 then 8,..,F in cycles 1-16; OPB_O=0xA on beats 0-14, 0xE on beat 15.
- Fabric returns nibbles 1..8 with last on the 8th, then rsp_ready held high -> rsp_data=0x87654321, status 00, rsp_valid in cycle 25 for exactly one cycle.
- Same, with RES1_I[2]=1 on beat 3 -> status 01, data 0x87654321; last on beat 4 instead -> status 10, data 0x00054321.
- TIMEOUT_EN, TIMEOUT_CYCLES=10, three beats then silence -> status 11, data 0x00000321, rsp_valid 10 cycles after the third beat; without macro -> no response after 1000 cycles.
- rsp_ready held low for 20 cycles -> rsp_valid/rsp_data stable, req_ready=0, extra result beats ignored.
